// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
//   Shared definitions for the shift_reg_ctl block: the Mode encodings
//   and the controller state type.
// -----------------------------------------------------------------------------
package shift_reg_pkg;

   // Mode input encodings
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Controller state: IDLE applies Mode each edge, SHIFT runs a sequenced shift
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage : shift_reg_pkg

// File: rtl/shift_step_ctr.sv
// -----------------------------------------------------------------------------
// shift_step_ctr
//   Loadable down-counter holding the number of shifts still to be done in a
//   sequenced shift. The 'last' flag marks the final remaining step.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high clear
//   load     in   load load_val into the counter
//   load_val in   CNT_W  remaining-step count to load
//   dec      in   decrement by one (saturates at zero)
//   last     out  counter equals one: the coming edge is the final step
// -----------------------------------------------------------------------------
module shift_step_ctr #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state is always written with non-blocking assignments
   // so every flop samples pre-edge values, independent of process order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(1));

endmodule : shift_step_ctr

// File: rtl/shift_reg_ctl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctl
//   Universal shift register with a multi-cycle shift controller: hold,
//   one-bit left/right shift, parallel load, and a Start/Busy/Done sequenced
//   shift of up to WIDTH positions at one bit per clock.
//
//   Optional feature macro: ROTATE_EN
//     defined   - Rot=1 on a shift edge recirculates the bit shifted out
//     undefined - Rot is ignored; shifts always take SinL/SinR
//
// Ports
//   Clk     in   rising-edge clock
//   Reset   in   asynchronous, active-high; clears all state
//   Mode    in   2      00 hold, 01 shift left, 10 shift right, 11 load
//   D       in   WIDTH  parallel load data
//   SinL    in   bit entering Q[0] on a left shift
//   SinR    in   bit entering Q[WIDTH-1] on a right shift
//   Rot     in   rotate select (ROTATE_EN builds only)
//   Start   in   request a sequenced shift of Amount positions
//   Amount  in   CNT_W  sequenced shift count (clamped to WIDTH)
//   Q       out  WIDTH  register contents
//   SoutL   out  Q[WIDTH-1]
//   SoutR   out  Q[0]
//   Busy    out  sequenced shift in progress (registered)
//   Done    out  one-cycle pulse after the final sequenced shift (registered)
// -----------------------------------------------------------------------------
module shift_reg_ctl
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [1:0]       Mode,
   input  logic [WIDTH-1:0] D,
   input  logic             SinL,
   input  logic             SinR,
   input  logic             Rot,
   input  logic             Start,
   input  logic [CNT_W-1:0] Amount,
   output logic [WIDTH-1:0] Q,
   output logic             SoutL,
   output logic             SoutR,
   output logic             Busy,
   output logic             Done
);

   localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

   state_t           state, next_state;
   logic [WIDTH-1:0] q_next;
   logic             dir_right, dir_right_next;   // latched sequenced direction
   logic             done_next;
   logic             ctr_load, ctr_dec, ctr_last;
   logic [CNT_W-1:0] n_amt;
   logic             fill_l, fill_r;
   logic [WIDTH-1:0] shl_val, shr_val;

   // Bits entering the vacated end on a shift
`ifdef ROTATE_EN
   assign fill_l = Rot ? Q[WIDTH-1] : SinL;
   assign fill_r = Rot ? Q[0]       : SinR;
`else
   logic unused_rot;
   assign unused_rot = Rot;
   assign fill_l     = SinL;
   assign fill_r     = SinR;
`endif

   assign shl_val = {Q[WIDTH-2:0], fill_l};
   assign shr_val = {fill_r, Q[WIDTH-1:1]};

   // Requests beyond WIDTH behave like WIDTH: every bit gets replaced anyway
   assign n_amt = (Amount > WIDTH_CNT) ? WIDTH_CNT : Amount;

   shift_step_ctr #(
      .CNT_W (CNT_W)
   ) u_step_ctr (
      .clk      (Clk),
      .reset    (Reset),
      .load     (ctr_load),
      .load_val (n_amt - CNT_W'(1)),
      .dec      (ctr_dec),
      .last     (ctr_last)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      next_state     = state;
      q_next         = Q;
      dir_right_next = dir_right;
      done_next      = 1'b0;
      ctr_load       = 1'b0;
      ctr_dec        = 1'b0;

      case (state)
         IDLE: begin
            case (Mode)
               MODE_LOAD: q_next = D;
               MODE_SHL, MODE_SHR: begin
                  if (Start) begin
                     dir_right_next = (Mode == MODE_SHR);
                     if (n_amt == '0) begin
                        done_next = 1'b1;
                     end else begin
                        q_next = (Mode == MODE_SHR) ? shr_val : shl_val;
                        if (n_amt == CNT_W'(1)) begin
                           done_next = 1'b1;
                        end else begin
                           // First shift happens now; counter holds the rest
                           ctr_load   = 1'b1;
                           next_state = SHIFT;
                        end
                     end
                  end else begin
                     q_next = (Mode == MODE_SHR) ? shr_val : shl_val;
                  end
               end
               default: ;   // MODE_HOLD
            endcase
         end

         SHIFT: begin
            q_next  = dir_right ? shr_val : shl_val;
            ctr_dec = 1'b1;
            if (ctr_last) begin
               done_next  = 1'b1;
               next_state = IDLE;
            end
         end

         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         Q         <= '0;
         dir_right <= 1'b0;
         Done      <= 1'b0;
      end else begin
         state     <= next_state;
         Q         <= q_next;
         dir_right <= dir_right_next;
         Done      <= done_next;
      end
   end

   // Busy is the state flop itself, so it is registered and excludes Done
   assign Busy  = (state == SHIFT);
   assign SoutL = Q[WIDTH-1];
   assign SoutR = Q[0];

endmodule : shift_reg_ctl

// File: tb/tb_shift_reg_ctl.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_ctl
//   Self-checking bench for shift_reg_ctl (WIDTH=8). A table of per-cycle
//   vectors covers single-step modes, sequenced shifts, back-to-back starts
//   and rotate; hand-written sequences cover clamping and reset mid-shift.
// -----------------------------------------------------------------------------
module tb_shift_reg_ctl;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             Clk;
   logic             Reset;
   logic [1:0]       Mode;
   logic [WIDTH-1:0] D;
   logic             SinL, SinR, Rot, Start;
   logic [CNT_W-1:0] Amount;
   logic [WIDTH-1:0] Q;
   logic             SoutL, SoutR, Busy, Done;

   int total = 0;
   int bad   = 0;

   shift_reg_ctl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Mode   (Mode),
      .D      (D),
      .SinL   (SinL),
      .SinR   (SinR),
      .Rot    (Rot),
      .Start  (Start),
      .Amount (Amount),
      .Q      (Q),
      .SoutL  (SoutL),
      .SoutR  (SoutR),
      .Busy   (Busy),
      .Done   (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]       mode;
      logic [WIDTH-1:0] d;
      logic             sinl;
      logic             sinr;
      logic             rot;
      logic             start;
      logic [CNT_W-1:0] amount;
      logic [WIDTH-1:0] exp_q;
      logic             exp_busy;
      logic             exp_done;
   } vec_t;

   vec_t vecs[$];

   // Expected rotate results depend on the build option
`ifdef ROTATE_EN
   localparam logic [7:0] ROT_L = 8'h03;   // 0x81 rotated left
   localparam logic [7:0] ROT_R = 8'h81;   // 0x03 rotated right
`else
   localparam logic [7:0] ROT_L = 8'h02;   // 0x81 << 1, SinL=0
   localparam logic [7:0] ROT_R = 8'h01;   // 0x02 >> 1, SinR=0
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [WIDTH-1:0] eq,
                             input logic eb, input logic ed);
      check({tag, " Q"},     32'(Q),     32'(eq));
      check({tag, " Busy"},  32'(Busy),  32'(eb));
      check({tag, " Done"},  32'(Done),  32'(ed));
      check({tag, " SoutL"}, 32'(SoutL), 32'(eq[WIDTH-1]));
      check({tag, " SoutR"}, 32'(SoutR), 32'(eq[0]));
   endtask

   task automatic drive(input logic [1:0] m, input logic [WIDTH-1:0] dd,
                        input logic sl, input logic sr, input logic r,
                        input logic st, input logic [CNT_W-1:0] amt);
      Mode = m; D = dd; SinL = sl; SinR = sr; Rot = r; Start = st; Amount = amt;
   endtask

   // Drive inputs, take one edge, sample 1 time unit later
   task automatic tick(input logic [1:0] m, input logic [WIDTH-1:0] dd,
                       input logic sl, input logic sr, input logic r,
                       input logic st, input logic [CNT_W-1:0] amt);
      drive(m, dd, sl, sr, r, st, amt);
      @(posedge Clk);
      #1;
   endtask

   task automatic add(input logic [1:0] m, input logic [7:0] dd, input logic sl,
                      input logic sr, input logic r, input logic st,
                      input logic [3:0] amt, input logic [7:0] eq,
                      input logic eb, input logic ed);
      vec_t v;
      v.mode = m; v.d = dd; v.sinl = sl; v.sinr = sr; v.rot = r;
      v.start = st; v.amount = amt; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   initial begin
      // ---------------- stimulus table: one row per clock edge -------------
      //   mode   d      sinl sinr rot st amt   exp_q  busy done
      // single-step modes
      add(2'b11, 8'hA5, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);   // load
      add(2'b01, 8'h00, 1, 0, 0, 0, 4'd0, 8'h4B, 0, 0);   // shl, SinL=1
      add(2'b00, 8'hFF, 0, 0, 0, 0, 4'd0, 8'h4B, 0, 0);   // hold
      add(2'b10, 8'h00, 0, 1, 0, 0, 4'd0, 8'hA5, 0, 0);   // shr, SinR=1
      add(2'b10, 8'h00, 0, 0, 0, 0, 4'd0, 8'h52, 0, 0);   // shr, SinR=0
      add(2'b11, 8'h3C, 0, 0, 0, 1, 4'd3, 8'h3C, 0, 0);   // Start+load = plain load
      add(2'b00, 8'h00, 0, 0, 0, 1, 4'd3, 8'h3C, 0, 0);   // Start+hold ignored
      add(2'b01, 8'h00, 0, 0, 0, 0, 4'd0, 8'h78, 0, 0);   // shl, SinL=0
      // sequenced right shift by 3 from 0xA5; Mode/D ignored while busy
      add(2'b11, 8'hA5, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
      add(2'b10, 8'h00, 0, 0, 0, 1, 4'd3, 8'h52, 1, 0);
      add(2'b11, 8'hFF, 0, 0, 0, 0, 4'd0, 8'h29, 1, 0);
      add(2'b00, 8'h00, 0, 0, 0, 0, 4'd0, 8'h14, 0, 1);
      add(2'b00, 8'h00, 0, 0, 0, 0, 4'd0, 8'h14, 0, 0);
      // Amount=0: Done next cycle, Q unchanged, never busy
      add(2'b01, 8'h00, 1, 0, 0, 1, 4'd0, 8'h14, 0, 1);
      add(2'b00, 8'h00, 0, 0, 0, 0, 4'd0, 8'h14, 0, 0);
      // back-to-back: N=1 right, then Start in the Done cycle, N=2 left
      add(2'b10, 8'h00, 0, 1, 0, 1, 4'd1, 8'h8A, 0, 1);
      add(2'b01, 8'h00, 0, 0, 0, 1, 4'd2, 8'h14, 1, 0);
      add(2'b00, 8'h00, 1, 0, 0, 0, 4'd0, 8'h29, 0, 1);
      add(2'b00, 8'h00, 0, 0, 0, 0, 4'd0, 8'h29, 0, 0);
      // rotate: sequenced left by 1, then single-step right
      add(2'b11, 8'h81, 0, 0, 0, 0, 4'd0, 8'h81, 0, 0);
      add(2'b01, 8'h00, 0, 0, 1, 1, 4'd1, ROT_L, 0, 1);
      add(2'b00, 8'h00, 0, 0, 0, 0, 4'd0, ROT_L, 0, 0);
      add(2'b10, 8'h00, 0, 0, 1, 0, 4'd0, ROT_R, 0, 0);
      add(2'b00, 8'h00, 0, 0, 0, 0, 4'd0, ROT_R, 0, 0);

      // ---------------- reset ----------------------------------------------
      drive(2'b00, '0, 0, 0, 0, 0, '0);
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #2;
      Reset = 1'b0;
      #1;
      check_outs("reset", 8'h00, 0, 0);

      // ---------------- table-driven vectors -------------------------------
      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].mode, vecs[i].d, vecs[i].sinl, vecs[i].sinr,
              vecs[i].rot, vecs[i].start, vecs[i].amount);
         check_outs($sformatf("vec%0d", i), vecs[i].exp_q,
                    vecs[i].exp_busy, vecs[i].exp_done);
      end

      // ---------------- Amount=12 clamps to 8 ------------------------------
      tick(2'b11, 8'hFF, 0, 0, 0, 0, 4'd0);
      check_outs("clamp load", 8'hFF, 0, 0);
      tick(2'b01, 8'h00, 0, 0, 0, 1, 4'd12);
      check_outs("clamp e1", 8'hFE, 1, 0);
      for (int k = 2; k <= 8; k++) begin
         logic [7:0] ff;
         ff = 8'hFF;
         tick(2'b00, 8'h00, 0, 0, 0, 0, 4'd0);
         check_outs($sformatf("clamp e%0d", k), ff << k, (k < 8), (k == 8));
      end
      tick(2'b00, 8'h00, 0, 0, 0, 0, 4'd0);
      check_outs("clamp after", 8'h00, 0, 0);

      // ---------------- reset mid-shift ------------------------------------
      tick(2'b11, 8'hA5, 0, 0, 0, 0, 4'd0);
      check_outs("rst load", 8'hA5, 0, 0);
      tick(2'b01, 8'h00, 1, 0, 0, 1, 4'd8);
      check_outs("rst e1", 8'h4B, 1, 0);
      tick(2'b00, 8'h00, 1, 0, 0, 0, 4'd0);
      check_outs("rst e2", 8'h97, 1, 0);
      tick(2'b00, 8'h00, 1, 0, 0, 0, 4'd0);
      check_outs("rst e3", 8'h2F, 1, 0);
      #2;
      Reset = 1'b1;
      #1;
      check_outs("rst immediate", 8'h00, 0, 0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(2'b00, 8'h00, 1, 0, 0, 0, 4'd0);
         check_outs($sformatf("rst post%0d", k), 8'h00, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_shift_reg_ctl
